// File: rtl/rv32_alu_sequencer_if.sv
// Request/result handshake and shared-slice bus of the RV32 ALU sequencer.
// The slave modport is the sequencer's view. The master modport is the side that faces the sequencer.
interface rv32_alu_sequencer_if #(
  parameter int XLEN  = 32,
  parameter int SLICE = 16
);
  logic             i_req_valid;
  logic             o_req_ready;
  logic [2:0]       i_op;
  logic [XLEN-1:0]  i_rs1;
  logic [XLEN-1:0]  i_rs2;
  logic             i_flush;
  logic             o_res_valid;
  logic             i_res_ready;
  logic [XLEN-1:0]  o_result;
  logic             o_illegal;
  logic [SLICE-1:0] o_adu_op_one;
  logic [SLICE-1:0] o_adu_op_two;
  logic             o_adu_c_in;
  logic [1:0]       o_adu_sel;
  logic [SLICE-1:0] i_adu_result;
  logic             i_adu_carry;

  modport slave (
    input  i_req_valid, i_op, i_rs1, i_rs2, i_flush, i_res_ready, i_adu_result, i_adu_carry,
    output o_req_ready, o_res_valid, o_result, o_illegal,
           o_adu_op_one, o_adu_op_two, o_adu_c_in, o_adu_sel
  );

  modport master (
    output i_req_valid, i_op, i_rs1, i_rs2, i_flush, i_res_ready, i_adu_result, i_adu_carry,
    input  o_req_ready, o_res_valid, o_result, o_illegal,
           o_adu_op_one, o_adu_op_two, o_adu_c_in, o_adu_sel
  );
endinterface

// File: rtl/rv32_alu_sequencer.sv
// Multicycle RV32 ALU controller. It runs one latched request through a shared SLICE-bit adder/logic slice,
// starting with the low slice. The carry is chained through a register between passes.
module rv32_alu_sequencer #(
  parameter int XLEN  = 32,
  parameter int SLICE = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  rv32_alu_sequencer_if.slave  bus
);

  localparam int NPASS = XLEN / SLICE;
  localparam int PW    = (NPASS > 1) ? $clog2(NPASS) : 1;

  if ((XLEN % SLICE) != 0) begin : g_bad_slice
    $error("rv32_alu_sequencer: XLEN must be a multiple of SLICE");
  end

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;
  typedef enum logic [2:0] {
    OP_ADD = 3'b000, OP_SUB = 3'b001, OP_OR  = 3'b010, OP_AND = 3'b011,
    OP_XOR = 3'b100, OP_SLTU = 3'b101, OP_SLT = 3'b110, OP_ILL = 3'b111
  } op_t;

  state_t          state_q, state_d;
  op_t             op_q;
  logic [XLEN-1:0] rs1_q, rs2_q, result_q;
  logic            carry_q, illegal_q;
  logic [PW-1:0]   pass_q;

  op_t  op_in;
  logic accept, last_pass, sub_in;
  logic a_msb, b_msb, d_msb, slt_lt, sltu_lt;

  assign op_in     = op_t'(bus.i_op);
  assign accept    = bus.i_req_valid && (state_q == S_IDLE);
  assign last_pass = (pass_q == PW'(NPASS - 1));
  assign sub_in    = (op_in == OP_SUB) || (op_in == OP_SLT) || (op_in == OP_SLTU);

  // Signed compare: rs2_q holds ~b, so the original b MSB is the inverted stored bit.
  assign a_msb   = rs1_q[XLEN-1];
  assign b_msb   = ~rs2_q[XLEN-1];
  assign d_msb   = bus.i_adu_result[SLICE-1];
  assign slt_lt  = d_msb ^ ((a_msb ^ b_msb) & (a_msb ^ d_msb));
  assign sltu_lt = ~bus.i_adu_carry;

  assign bus.o_result  = result_q;
  assign bus.o_illegal = illegal_q && (state_q == S_DONE);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d          = state_q;
    bus.o_req_ready  = 1'b0;
    bus.o_res_valid  = 1'b0;
    bus.o_adu_op_one = '0;
    bus.o_adu_op_two = '0;
    bus.o_adu_c_in   = 1'b0;
    bus.o_adu_sel    = 2'b00;
    case (state_q)
      S_IDLE: begin
        bus.o_req_ready = 1'b1;
        if (accept) state_d = (op_in == OP_ILL) ? S_DONE : S_EXEC;
      end
      S_EXEC: begin
        bus.o_adu_op_one = rs1_q[32'(pass_q)*SLICE +: SLICE];
        bus.o_adu_op_two = rs2_q[32'(pass_q)*SLICE +: SLICE];
        bus.o_adu_c_in   = carry_q;
        case (op_q)
          OP_OR:   bus.o_adu_sel = 2'b01;
          OP_AND:  bus.o_adu_sel = 2'b10;
          OP_XOR:  bus.o_adu_sel = 2'b11;
          default: bus.o_adu_sel = 2'b00;
        endcase
        if (last_pass) state_d = S_DONE;
      end
      S_DONE: begin
        bus.o_res_valid = 1'b1;
        if (bus.i_res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (bus.i_flush) state_d = S_IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      op_q      <= OP_ADD;
      rs1_q     <= '0;
      rs2_q     <= '0;
      carry_q   <= 1'b0;
      pass_q    <= '0;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else if (bus.i_flush) begin
      carry_q   <= 1'b0;
      pass_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (accept) begin
          op_q      <= op_in;
          rs1_q     <= bus.i_rs1;
          rs2_q     <= sub_in ? ~bus.i_rs2 : bus.i_rs2;
          carry_q   <= sub_in;
          pass_q    <= '0;
          illegal_q <= (op_in == OP_ILL);
          if (op_in == OP_ILL) result_q <= '0;
        end
        S_EXEC: begin
          result_q[32'(pass_q)*SLICE +: SLICE] <= bus.i_adu_result;
          carry_q <= bus.i_adu_carry;
          pass_q  <= last_pass ? '0 : pass_q + 1'b1;
          if (last_pass && op_q == OP_SLTU) result_q <= {{(XLEN-1){1'b0}}, sltu_lt};
          if (last_pass && op_q == OP_SLT)  result_q <= {{(XLEN-1){1'b0}}, slt_lt};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_alu_sequencer.sv
// Self-checking bench for rv32_alu_sequencer: directed corner cases and randomized ops.
// A behavioural 16-bit slice feeds the DUT. Results are compared against whole-word 32-bit reference arithmetic.
module tb_rv32_alu_sequencer;
  localparam int XLEN  = 32;
  localparam int SLICE = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rv32_alu_sequencer_if #(.XLEN(XLEN), .SLICE(SLICE)) bus ();
  rv32_alu_sequencer #(.XLEN(XLEN), .SLICE(SLICE)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // External shared slice: same-cycle result and carry-out.
  always_comb begin
    bus.i_adu_result = '0;
    bus.i_adu_carry  = 1'b0;
    case (bus.o_adu_sel)
      2'b00: {bus.i_adu_carry, bus.i_adu_result} =
               {1'b0, bus.o_adu_op_one} + {1'b0, bus.o_adu_op_two} + {16'd0, bus.o_adu_c_in};
      2'b01: bus.i_adu_result = bus.o_adu_op_one | bus.o_adu_op_two;
      2'b10: bus.i_adu_result = bus.o_adu_op_one & bus.o_adu_op_two;
      default: bus.i_adu_result = bus.o_adu_op_one ^ bus.o_adu_op_two;
    endcase
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a | b;
      3'd3: return a & b;
      3'd4: return a ^ b;
      3'd5: return {31'd0, (a < b)};
      3'd6: return {31'd0, ($signed(a) < $signed(b))};
      default: return 32'd0;
    endcase
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] exp;
    logic [31:0] b_eff;
    int lat;
    exp   = ref_alu(op, a, b);
    b_eff = (op == 3'd1 || op == 3'd5 || op == 3'd6) ? ~b : b;
    @(negedge clk);
    check("req_ready_idle", bus.o_req_ready, 1);
    bus.i_req_valid = 1'b1;
    bus.i_op        = op;
    bus.i_rs1       = a;
    bus.i_rs2       = b;
    lat = 0;
    do begin
      @(negedge clk);
      bus.i_req_valid = 1'b0;
      lat++;
      if (lat == 1 && op != 3'd7) begin
        check("pass0_op_one", bus.o_adu_op_one, a[15:0]);
        check("pass0_op_two", bus.o_adu_op_two, b_eff[15:0]);
        check("pass0_c_in", bus.o_adu_c_in, (op == 3'd1 || op == 3'd5 || op == 3'd6));
      end
    end while (!bus.o_res_valid && lat < 20);
    check("latency", lat, (op == 3'd7) ? 1 : 3);
    if (!bus.o_res_valid) return;
    check("result", bus.o_result, exp);
    check("illegal", bus.o_illegal, (op == 3'd7));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", bus.o_res_valid, 1);
      check("hold_result", bus.o_result, exp);
      check("hold_req_ready", bus.o_req_ready, 0);
    end
    bus.i_res_ready = 1'b1;
    @(negedge clk);
    bus.i_res_ready = 1'b0;
    check("post_valid", bus.o_res_valid, 0);
    check("post_req_ready", bus.o_req_ready, 1);
    check("post_result_kept", bus.o_result, exp);
    check("idle_adu_ops", {bus.o_adu_op_one, bus.o_adu_op_two}, 0);
    check("idle_adu_ctl", {bus.o_adu_c_in, bus.o_adu_sel}, 0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_req_ready"}, bus.o_req_ready, 1);
    check({tag, "_res_valid"}, bus.o_res_valid, 0);
    check({tag, "_result"}, bus.o_result, 0);
    check({tag, "_illegal"}, bus.o_illegal, 0);
    check({tag, "_adu_ops"}, {bus.o_adu_op_one, bus.o_adu_op_two}, 0);
    check({tag, "_adu_ctl"}, {bus.o_adu_c_in, bus.o_adu_sel}, 0);
  endtask

  logic [31:0] edge_vals [6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_FFFF};

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    rst             = 1'b1;
    bus.i_req_valid = 1'b0;
    bus.i_op        = '0;
    bus.i_rs1       = '0;
    bus.i_rs2       = '0;
    bus.i_flush     = 1'b0;
    bus.i_res_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;

    run_op(3'd0, 32'h0000_FFFF, 32'h0000_0001, 0);
    run_op(3'd1, 32'h0000_0000, 32'h0000_0001, 0);
    run_op(3'd2, 32'hF0F0_1234, 32'h0FF0_FF00, 0);
    run_op(3'd3, 32'hF0F0_1234, 32'h0FF0_FF00, 0);
    run_op(3'd4, 32'hF0F0_1234, 32'h0FF0_FF00, 0);
    run_op(3'd6, 32'h8000_0000, 32'h0000_0001, 0);
    run_op(3'd5, 32'h8000_0000, 32'h0000_0001, 0);
    run_op(3'd6, 32'h7FFF_FFFF, 32'h8000_0000, 0);
    run_op(3'd0, 32'h1234_5678, 32'h0FED_CBA9, 5);
    run_op(3'd7, 32'hDEAD_BEEF, 32'h1, 2);

    // Flush during pass 1 must drop the op entirely.
    @(negedge clk);
    bus.i_req_valid = 1'b1; bus.i_op = 3'd0; bus.i_rs1 = 32'd7; bus.i_rs2 = 32'd9;
    @(negedge clk);
    bus.i_req_valid = 1'b0;
    @(negedge clk);
    bus.i_flush = 1'b1;
    @(negedge clk);
    bus.i_flush = 1'b0;
    check("flush_req_ready", bus.o_req_ready, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("flush_no_valid", bus.o_res_valid, 0);
    end
    run_op(3'd0, 32'd2, 32'd3, 0);

    // Flush wins over a simultaneous accept.
    @(negedge clk);
    bus.i_req_valid = 1'b1; bus.i_op = 3'd4; bus.i_flush = 1'b1;
    @(negedge clk);
    bus.i_req_valid = 1'b0; bus.i_flush = 1'b0;
    check("flush_accept_ready", bus.o_req_ready, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("flush_accept_no_valid", bus.o_res_valid, 0);
    end

    // Reset mid-EXEC behaves as power-up.
    @(negedge clk);
    bus.i_req_valid = 1'b1; bus.i_op = 3'd1; bus.i_rs1 = 32'h5; bus.i_rs2 = 32'h9;
    @(negedge clk);
    bus.i_req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("mid_reset");

    for (int n = 0; n < 40; n++) begin
      op = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom;
      run_op(op, a, b, $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
